// File: rtl/fifo_queue.sv
// Circular FIFO queue of DEPTH words with show-ahead read data, occupancy count
// and registered one-cycle error pulses for rejected push/pop requests.
module fifo_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // Request semantics: push and pop are level requests sampled every rising
    // edge; a request high for N cycles is N requests. A push is accepted unless
    // the queue is full with no pop in the same cycle; a pop is accepted unless
    // the queue is empty. A rejected request raises its error flag for exactly
    // the following cycle. There is no back-pressure signal to the requester.

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_err_q, rd_err_d;

    logic push_ok;
    logic pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_err_d = 1'b0;
        rd_err_d = 1'b0;

        // When full, a simultaneous pop frees the slot the push writes into.
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        wr_err_d = push && !push_ok;
        rd_err_d = pop && !pop_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is never cleared; stale words stay hidden behind empty.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;
    assign wr_err  = wr_err_q;
    assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue: a vector table for short sequences plus
// hand-written fill/drain, full push+pop and pointer-wrap scenarios.
module tb_fifo_queue;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              wr_err;
    logic              rd_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];

    fifo_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .wr_err  (wr_err),
        .rd_err  (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pu;
        logic       po;
        logic [7:0] din;
        logic [4:0] cnt;
        logic [7:0] rd;
        logic       emp;
        logic       ful;
        logic       werr;
        logic       rerr;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic pu, input logic po, input logic [7:0] d);
        reset   = r;
        push    = pu;
        pop     = po;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic [7:0] d,
                                input logic [4:0] c, input logic [7:0] rd, input logic e,
                                input logic f, input logic we, input logic re);
        vec_t v;
        v.rst = r; v.pu = pu; v.po = po; v.din = d; v.cnt = c;
        v.rd = rd; v.emp = e; v.ful = f; v.werr = we; v.rerr = re;
        return v;
    endfunction

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; wr_data = '0;

        //              rst   push  pop   din    cnt  rd     emp  full werr rerr
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 8'h33, 5'd3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 8'h66, 5'd1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'h01, 5'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 8'h02, 5'd2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 8'h03, 5'd3, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 8'h04, 5'd4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 8'h05, 5'd5, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 8'h99, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 8'h77, 5'd1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].rst, vecs[i].pu, vecs[i].po, vecs[i].din);
            chk($sformatf("vec%0d_count", i),   32'(count),   32'(vecs[i].cnt));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_empty", i),   32'(empty),   32'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i),    32'(full),    32'(vecs[i].ful));
            chk($sformatf("vec%0d_wr_err", i),  32'(wr_err),  32'(vecs[i].werr));
            chk($sformatf("vec%0d_rd_err", i),  32'(rd_err),  32'(vecs[i].rerr));
        end

        // Fill to full, reject an extra push, drain in order.
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        apply(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_wr_err", 32'(wr_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        idle();
        chk("ovf_wr_err_clear", 32'(wr_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_rd_data", 32'(rd_data), 32'(i));
            apply(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rd_zero", 32'(rd_data), 32'd0);
        chk("drain_rd_err", 32'(rd_err), 32'd0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        apply(1'b0, 1'b1, 1'b1, 8'h5A);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_wr_err", 32'(wr_err), 32'd0);
        chk("fullpp_full", 32'(full), 32'd1);
        chk("fullpp_rd_data", 32'(rd_data), 32'h81);
        for (int i = 0; i < 15; i++) apply(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fullpp_last", 32'(rd_data), 32'h5A);
        chk("fullpp_count1", 32'(count), 32'd1);

        // Pointer wrap: 10 in, 10 out, then 10 more across the wrap point.
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_mid_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        chk("wrap_count", 32'(count), 32'd10);
        while (exp_q.size() > 0) begin
            chk("wrap_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            apply(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("wrap_end_empty", 32'(empty), 32'd1);
        chk("wrap_end_count", 32'(count), 32'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
